// File: rtl/nzr_pkg.sv
// nzr_pkg -- shared definitions for the WS2812B-style NZR link (receiver and
// transmitter side).
//   - nominal line timing in nanoseconds plus a helper that turns it into
//     clk cycles for a given clock frequency
//   - counter width used by every pulse-width counter on the link
//   - receiver FSM state encoding
package nzr_pkg;

  localparam int unsigned CLK_MHZ_DEF   = 50;

  // Nominal line timing; converted to cycles with ns_to_cycles().
  localparam int unsigned T_THRESH_NS   = 600;     // 0/1 decision point
  localparam int unsigned T_MINHIGH_NS  = 100;     // shorter high = glitch
  localparam int unsigned T_MAXHIGH_NS  = 5000;    // longer high = stuck line
  localparam int unsigned T_RESET_NS    = 280000;  // latch / reset code

  localparam int unsigned CNT_W = 14;
  localparam int unsigned GRB_W = 24;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } nzr_state_e;

  function automatic int unsigned ns_to_cycles(input int unsigned mhz,
                                               input int unsigned ns);
    return (mhz * ns) / 1000;
  endfunction

  // Counters stick at all-ones instead of wrapping, so a very long low or
  // high never masquerades as a short one.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/nzr_bit_decode.sv
// nzr_bit_decode -- synchronizes the raw serial line, measures high and low
// pulse widths and classifies each high pulse.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   dataIn       asynchronous serial line
//   riseEdge     synchronized rising edge (one cycle)
//   bitStrobe    valid bit finished (synchronized falling edge, width ok)
//   bitValue     value of the bit on bitStrobe (1 = long high)
//   glitch       falling edge of a high pulse shorter than T_MINHIGH
//   stuckHigh    one-cycle pulse once the line has been high > T_MAXHIGH
//   lowTimeout   level: line low for at least T_RESET cycles
module nzr_bit_decode
  import nzr_pkg::*;
#(
  parameter int unsigned T_THRESH  = ns_to_cycles(CLK_MHZ_DEF, T_THRESH_NS),
  parameter int unsigned T_MINHIGH = ns_to_cycles(CLK_MHZ_DEF, T_MINHIGH_NS),
  parameter int unsigned T_MAXHIGH = ns_to_cycles(CLK_MHZ_DEF, T_MAXHIGH_NS),
  parameter int unsigned T_RESET   = ns_to_cycles(CLK_MHZ_DEF, T_RESET_NS)
) (
  input  logic clk,
  input  logic reset,
  input  logic dataIn,
  output logic riseEdge,
  output logic bitStrobe,
  output logic bitValue,
  output logic glitch,
  output logic stuckHigh,
  output logic lowTimeout
);

  localparam cnt_t THRESH_C = cnt_t'(T_THRESH);
  localparam cnt_t MIN_C    = cnt_t'(T_MINHIGH);
  localparam cnt_t MAX_C    = cnt_t'(T_MAXHIGH);
  localparam cnt_t RESET_C  = cnt_t'(T_RESET);

  logic meta_q, sync_q, prev_q;
  cnt_t hi_cnt_q, hi_cnt_d;
  cnt_t lo_cnt_q, lo_cnt_d;
  logic fall;

  // meta_q/sync_q form the synchronizer; prev_q is only for edge detection.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      prev_q   <= 1'b0;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      meta_q   <= dataIn;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign riseEdge = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

  // hi_cnt_q holds the width of the current/last high pulse; it is left
  // untouched while the line is low so it is still valid on the falling edge.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (sync_q) begin
      hi_cnt_d = riseEdge ? cnt_t'(1) : sat_inc(hi_cnt_q);
      lo_cnt_d = '0;
    end else begin
      lo_cnt_d = sat_inc(lo_cnt_q);
    end
  end

  assign bitStrobe  = fall & (hi_cnt_q >= MIN_C);
  assign glitch     = fall & (hi_cnt_q <  MIN_C);
  assign bitValue   = (hi_cnt_q >= THRESH_C);
  // On the rise cycle hi_cnt_q still carries the previous pulse width, so it
  // must not be compared. hi_cnt_q == MAX_C means MAX_C+1 cycles high so far.
  assign stuckHigh  = sync_q & ~riseEdge & (hi_cnt_q == MAX_C);
  assign lowTimeout = ~sync_q & (lo_cnt_q >= RESET_C);

endmodule

// File: rtl/nzr_receiver.sv
// nzr_receiver -- WS2812B serial line receiver. Decodes 24-bit GRB pixels,
// numbers them within a frame and reports frame latches and line errors.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   dataIn       asynchronous serial line
//   grbOut       last decoded pixel, G[23:16] R[15:8] B[7:0]
//   grbValid     one-cycle pulse, grbOut/pixelIndex valid
//   pixelIndex   zero-based index of the pixel on grbOut (saturates at 255)
//   frameDone    one-cycle pulse when a frame is latched
//   pixelCount   complete pixels in the frame just closed
//   bitError     one-cycle pulse: glitch, stuck-high line, or partial pixel
//   lineIdle     resynchronizing, or line low for at least T_RESET cycles
module nzr_receiver
  import nzr_pkg::*;
#(
  parameter int unsigned CLK_MHZ   = CLK_MHZ_DEF,
  parameter int unsigned T_THRESH  = ns_to_cycles(CLK_MHZ, T_THRESH_NS),
  parameter int unsigned T_MINHIGH = ns_to_cycles(CLK_MHZ, T_MINHIGH_NS),
  parameter int unsigned T_MAXHIGH = ns_to_cycles(CLK_MHZ, T_MAXHIGH_NS),
  parameter int unsigned T_RESET   = ns_to_cycles(CLK_MHZ, T_RESET_NS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dataIn,
  output logic [GRB_W-1:0] grbOut,
  output logic             grbValid,
  output logic [7:0]       pixelIndex,
  output logic             frameDone,
  output logic [7:0]       pixelCount,
  output logic             bitError,
  output logic             lineIdle
);

  logic rise_edge, bit_strobe, bit_value, glitch, stuck_high, low_timeout;

  nzr_bit_decode #(
    .T_THRESH  (T_THRESH),
    .T_MINHIGH (T_MINHIGH),
    .T_MAXHIGH (T_MAXHIGH),
    .T_RESET   (T_RESET)
  ) u_bit_decode (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (dataIn),
    .riseEdge   (rise_edge),
    .bitStrobe  (bit_strobe),
    .bitValue   (bit_value),
    .glitch     (glitch),
    .stuckHigh  (stuck_high),
    .lowTimeout (low_timeout)
  );

  nzr_state_e       state_q, state_d;
  logic [GRB_W-1:0] shift_q, shift_d;
  logic [GRB_W-1:0] grb_q, grb_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       pix_idx_q, pix_idx_d;
  logic [7:0]       pixel_index_q, pixel_index_d;
  logic [7:0]       pixel_count_q, pixel_count_d;
  logic             grb_valid_q, grb_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             bit_error_q, bit_error_d;
  // Set by any shifted bit, cleared at frame close: a latch with no data in
  // between must not produce a second frameDone or overwrite pixelCount.
  logic             any_bit_q, any_bit_d;
  logic [GRB_W-1:0] shift_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SYNC;
      shift_q       <= '0;
      grb_q         <= '0;
      bit_cnt_q     <= '0;
      pix_idx_q     <= '0;
      pixel_index_q <= '0;
      pixel_count_q <= '0;
      grb_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      bit_error_q   <= 1'b0;
      any_bit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      grb_q         <= grb_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_idx_q     <= pix_idx_d;
      pixel_index_q <= pixel_index_d;
      pixel_count_q <= pixel_count_d;
      grb_valid_q   <= grb_valid_d;
      frame_done_q  <= frame_done_d;
      bit_error_q   <= bit_error_d;
      any_bit_q     <= any_bit_d;
    end
  end

  assign shift_next = {shift_q[GRB_W-2:0], bit_value};

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    grb_d         = grb_q;
    bit_cnt_d     = bit_cnt_q;
    pix_idx_d     = pix_idx_q;
    pixel_index_d = pixel_index_q;
    pixel_count_d = pixel_count_q;
    grb_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    bit_error_d   = 1'b0;
    any_bit_d     = any_bit_q;

    unique case (state_q)
      S_SYNC: begin
        if (low_timeout) begin
          state_d   = S_LOW;
          bit_cnt_d = '0;
          pix_idx_d = '0;
          any_bit_d = 1'b0;
        end
      end

      S_LOW: begin
        if (rise_edge) begin
          state_d = S_HIGH;
        end else if (low_timeout && any_bit_q) begin
          // Frame close; a partial pixel is dropped and flagged.
          pixel_count_d = pix_idx_q;
          frame_done_d  = 1'b1;
          pix_idx_d     = '0;
          any_bit_d     = 1'b0;
          if (bit_cnt_q != 5'd0) begin
            bit_error_d = 1'b1;
            bit_cnt_d   = '0;
          end
        end
      end

      S_HIGH: begin
        if (stuck_high) begin
          bit_error_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_SYNC;
        end else if (glitch) begin
          bit_error_d = 1'b1;
          state_d     = S_LOW;
        end else if (bit_strobe) begin
          state_d   = S_LOW;
          shift_d   = shift_next;
          any_bit_d = 1'b1;
          if (bit_cnt_q == 5'd23) begin
            grb_d         = shift_next;
            grb_valid_d   = 1'b1;
            pixel_index_d = pix_idx_q;
            pix_idx_d     = (pix_idx_q == 8'hFF) ? pix_idx_q : pix_idx_q + 8'd1;
            bit_cnt_d     = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      default: state_d = S_SYNC;
    endcase
  end

  assign grbOut     = grb_q;
  assign grbValid   = grb_valid_q;
  assign pixelIndex = pixel_index_q;
  assign frameDone  = frame_done_q;
  assign pixelCount = pixel_count_q;
  assign bitError   = bit_error_q;
  assign lineIdle   = (state_q == S_SYNC) | low_timeout;

endmodule

// File: tb/tb_nzr_receiver.sv
// tb_nzr_receiver -- scoreboard bench for nzr_receiver. Stimulus tasks update
// a pixel/frame-level model of the link and queue expected events; a monitor
// on the falling clock edge compares every grbValid/frameDone/bitError pulse.
// The latch time is scaled down to keep the run short.
`timescale 1ns/1ps
module tb_nzr_receiver;

  localparam int T_RESET_TB = 1500;
  localparam int LATCH      = T_RESET_TB + 50;
  localparam int T_THR      = 30;
  localparam int T_MAXH     = 250;

  logic        clk, reset, data_in;
  logic [23:0] grbOut;
  logic [7:0]  pixelIndex, pixelCount;
  logic        grbValid, frameDone, bitError, lineIdle;

  nzr_receiver #(.T_RESET(T_RESET_TB)) dut (
    .clk        (clk),
    .reset      (reset),
    .dataIn     (data_in),
    .grbOut     (grbOut),
    .grbValid   (grbValid),
    .pixelIndex (pixelIndex),
    .frameDone  (frameDone),
    .pixelCount (pixelCount),
    .bitError   (bitError),
    .lineIdle   (lineIdle)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct { logic [23:0] grb; logic [7:0] idx; } pix_t;
  typedef struct { logic [7:0] cnt; logic err; } frame_t;

  pix_t   exp_pix[$];
  frame_t exp_frame[$];
  int     exp_err = 0;

  int n_checks = 0;
  int n_pass   = 0;

  // Link model: is the receiver synchronized, pixels and bits in this frame.
  bit          m_synced = 1'b0;
  bit          m_any    = 1'b0;
  int          m_pix    = 0;
  int          m_bits   = 0;
  logic [23:0] m_shift  = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  task automatic drive(input logic lvl, input int n);
    data_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    drive(1'b1, hi);
    if (m_synced) begin
      m_any   = 1'b1;
      m_shift = {m_shift[22:0], b};
      m_bits++;
      if (m_bits == 24) begin
        exp_pix.push_back('{grb: m_shift, idx: sat8(m_pix)});
        m_pix++;
        m_bits = 0;
      end
    end
    drive(1'b0, lo);
  endtask

  task automatic glitch(input int hi, input int lo);
    drive(1'b1, hi);
    if (m_synced) exp_err++;
    drive(1'b0, lo);
  endtask

  task automatic stuck(input int n);
    if (m_synced && n > T_MAXH) begin
      exp_err++;
      m_synced = 1'b0;
      m_bits   = 0;
    end
    drive(1'b1, n);
  endtask

  task automatic latch();
    if (!m_synced) begin
      m_synced = 1'b1;
      m_pix    = 0;
      m_bits   = 0;
      m_any    = 1'b0;
    end else if (m_any) begin
      exp_frame.push_back('{cnt: sat8(m_pix), err: (m_bits != 0)});
      m_pix  = 0;
      m_bits = 0;
      m_any  = 1'b0;
    end
    drive(1'b0, LATCH);
  endtask

  // rnd=0: fixed 20/43 (zero) and 40/23 (one); rnd=1: random legal widths.
  task automatic send_bits(input logic [23:0] v, input int nbits, input bit rnd,
                           input int glitch_after);
    for (int k = 0; k < nbits; k++) begin
      bit b;
      int hi, lo;
      b = v[23-k];
      if (rnd) begin
        hi = b ? int'($urandom_range(120, T_THR)) : int'($urandom_range(T_THR-1, 5));
        lo = int'($urandom_range(40, 3));
      end else begin
        hi = b ? 40 : 20;
        lo = b ? 23 : 43;
      end
      send_bit(b, hi, lo);
      if (k == glitch_after) glitch(3, 20);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m_synced = 1'b0;
    m_any    = 1'b0;
    m_pix    = 0;
    m_bits   = 0;
    drive(1'b0, 4);
    @(negedge clk);
    check("rst_grbOut",     32'(grbOut),     32'h0);
    check("rst_pixelIndex", 32'(pixelIndex), 32'h0);
    check("rst_pixelCount", 32'(pixelCount), 32'h0);
    check("rst_grbValid",   32'(grbValid),   32'h0);
    check("rst_frameDone",  32'(frameDone),  32'h0);
    check("rst_bitError",   32'(bitError),   32'h0);
    check("rst_lineIdle",   32'(lineIdle),   32'h1);
    reset = 1'b0;
  endtask

  // Monitor: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    pix_t   p;
    frame_t f;
    if (grbValid) begin
      check("grbValid_expected", 32'(exp_pix.size() != 0), 32'h1);
      if (exp_pix.size() != 0) begin
        p = exp_pix.pop_front();
        check("grbOut",     32'(grbOut),     32'(p.grb));
        check("pixelIndex", 32'(pixelIndex), 32'(p.idx));
      end
    end
    if (frameDone) begin
      check("frameDone_expected", 32'(exp_frame.size() != 0), 32'h1);
      if (exp_frame.size() != 0) begin
        f = exp_frame.pop_front();
        check("pixelCount",     32'(pixelCount), 32'(f.cnt));
        check("frame_bitError", 32'(bitError),   32'(f.err));
      end
    end else if (bitError) begin
      check("bitError_expected", 32'(exp_err != 0), 32'h1);
      if (exp_err != 0) exp_err--;
    end
  end

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    do_reset();

    // 1: single pixel 0x00FF00
    latch();
    send_bits(24'h00FF00, 24, 1'b0, -1);
    latch();

    // 2: five back-to-back pixels; mid-frame the line is not idle
    send_bits(24'h123456, 24, 1'b0, -1);
    send_bits(24'hABCDEF, 24, 1'b0, -1);
    @(negedge clk);
    check("lineIdle_midframe", 32'(lineIdle), 32'h0);
    send_bits(24'h000001, 24, 1'b0, -1);
    send_bits(24'h800000, 24, 1'b0, -1);
    send_bits(24'hFFFFFF, 24, 1'b0, -1);
    latch();

    // 3: 3-cycle glitch between bits 10 and 11
    send_bits(24'hA5C33C, 24, 1'b0, 10);
    latch();

    // 4: partial pixel at latch
    send_bits(24'hF0F0F0, 12, 1'b0, -1);
    latch();

    // 5: stuck-high mid-pixel, following pixel ignored until resync
    send_bits(24'h777777, 10, 1'b0, -1);
    stuck(1000);
    drive(1'b0, 50);
    @(negedge clk);
    check("lineIdle_after_stuck", 32'(lineIdle), 32'h1);
    send_bits(24'h5A5A5A, 24, 1'b0, -1);
    latch();
    send_bits(24'h0F0F0F, 24, 1'b0, -1);
    latch();

    // 6: reset at bit 7 of pixel 2, then a clean frame
    send_bits(24'h111111, 24, 1'b0, -1);
    send_bits(24'h222222, 24, 1'b0, -1);
    send_bits(24'h333333, 7, 1'b0, -1);
    do_reset();
    latch();
    send_bits(24'h444444, 24, 1'b0, -1);
    send_bits(24'h555555, 24, 1'b0, -1);
    latch();

    // 7: width boundaries 5/29 (zero), 30/250 (one), plus a 4-cycle glitch
    for (int k = 0; k < 24; k++) begin
      int w;
      case (k % 4)
        0: w = 5;
        1: w = 29;
        2: w = 30;
        default: w = 250;
      endcase
      send_bit(w >= T_THR, w, 20);
      if (k == 5) glitch(4, 20);
    end
    latch();

    // 8: random pixels with random legal timing
    for (int fr = 0; fr < 2; fr++) begin
      int np;
      np = int'($urandom_range(3, 1));
      for (int i = 0; i < np; i++) send_bits(24'($urandom()), 24, 1'b1, -1);
      latch();
    end

    // 9: low counter must saturate, not wrap, on a very long idle line
    drive(1'b0, 16384 + 400 - LATCH);
    @(negedge clk);
    check("lineIdle_long_low", 32'(lineIdle), 32'h1);

    drive(1'b0, 20);
    check("pix_queue_drained",   32'(exp_pix.size()),   32'h0);
    check("frame_queue_drained", 32'(exp_frame.size()), 32'h0);
    check("err_queue_drained",   32'(exp_err),          32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
